// File: rtl/palette_pkg.sv
// Shared definitions for the palette bank: default colour table, byte lane
// width and the control FSM state encoding.
package palette_pkg;

  localparam int BYTE_W = 8;
  localparam int PAL_N  = 16;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } pal_state_e;

  localparam logic [11:0] DEFAULT_PAL [PAL_N] = '{
    12'h000, 12'hFFF, 12'h800, 12'hAFE, 12'hC4C, 12'h0C5, 12'h00A, 12'hEE7,
    12'hD85, 12'h640, 12'hF77, 12'h333, 12'h777, 12'hAF6, 12'h08F, 12'hBBB
  };

  // Power-on colour for entry n; entries beyond the table load as black.
  function automatic logic [11:0] pal_default(input logic [31:0] n);
    if (n < 32'(PAL_N)) return DEFAULT_PAL[n[3:0]];
    return 12'h000;
  endfunction

endpackage

// File: rtl/palette_bank_mem.sv
// One palette bank: byte-enabled write port and a registered read port
// that returns the contents from before a same-edge write.
module palette_bank_mem
  import palette_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       we_i,
  input  logic [DATA_W/BYTE_W-1:0]   ben_i,
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       rd_en_i,
  input  logic [ADDR_W-1:0]          rd_addr_i,
  output logic [DATA_W-1:0]          rd_data_o
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < NB; k++) begin
        if (ben_i[k]) mem[addr_i][k*BYTE_W +: BYTE_W] <= wdata_i[k*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_o <= '0;
    end else if (rd_en_i) begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

endmodule

// File: rtl/palette_bank.sv
// Multi-bank display palette: default-load sequencer, byte-enabled writes,
// 1-cycle display reads with write bypass, and vsync-aligned bank swapping.
module palette_bank
  import palette_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NBANKS = 2,
  localparam int BW    = $clog2(NBANKS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [BW-1:0]             wr_bank_i,
  input  logic [ADDR_W-1:0]         wr_addr_i,
  input  logic [DATA_W/8-1:0]       ben_i,
  input  logic [DATA_W-1:0]         wr_data_i,
  input  logic                      rd_en_i,
  input  logic [ADDR_W-1:0]         rd_addr_i,
  output logic [DATA_W-1:0]         rd_data_o,
  output logic                      rd_valid_o,
  input  logic                      swap_req_i,
  input  logic                      vsync_i,
  input  logic                      clear_req_i,
  output logic [BW-1:0]             active_bank_o,
  output logic                      busy_o,
  output logic [0:0]                dbg_state_o
);

  localparam int NB = DATA_W / BYTE_W;

  // Write handshake: a write is taken on any edge where wr_valid_i && wr_ready_o;
  // wr_ready_o is low for the whole default-load sequence and high otherwise.

  pal_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                init_active;
  logic                wr_fire;
  logic [DATA_W-1:0]   init_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_INIT: begin
        if (clear_req_i) begin
          idx_d = '0;
        end else if (idx_q == '1) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        if (clear_req_i) begin
          state_d = ST_INIT;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        idx_d   = '0;
      end
    endcase
  end

  assign init_active = (state_q == ST_INIT);
  assign busy_o      = init_active;
  assign wr_ready_o  = !init_active;
  assign wr_fire     = wr_valid_i && wr_ready_o;
  assign init_data   = DATA_W'(pal_default(32'(idx_q)));
  assign dbg_state_o = state_q;

  // Bank swap: a request waits for the next vsync; repeated requests merge.
  logic [BW-1:0] active_q;
  logic          swap_pend_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q    <= '0;
      swap_pend_q <= 1'b0;
    end else if (vsync_i && (swap_pend_q || swap_req_i)) begin
      active_q    <= active_q + BW'(1);
      swap_pend_q <= 1'b0;
    end else if (swap_req_i) begin
      swap_pend_q <= 1'b1;
    end
  end

  assign active_bank_o = active_q;

  logic [DATA_W-1:0] bank_rd [NBANKS];

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic sel;
    assign sel = wr_fire && (wr_bank_i == BW'(b));

    palette_bank_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_mem (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .we_i      (init_active || sel),
      .ben_i     (init_active ? {NB{1'b1}} : ben_i),
      .addr_i    (init_active ? idx_q : wr_addr_i),
      .wdata_i   (init_active ? init_data : wr_data_i),
      .rd_en_i   (rd_en_i),
      .rd_addr_i (rd_addr_i),
      .rd_data_o (bank_rd[b])
    );
  end

  // Read-side context captured with each read so rd_data_o holds between reads
  // and the bank seen is the one active before any same-edge swap.
  logic              rd_valid_q;
  logic [BW-1:0]     rd_bank_q;
  logic              rd_init_q;
  logic [NB-1:0]     byp_ben_q;
  logic [DATA_W-1:0] byp_data_q;
  logic              byp_hit;

  assign byp_hit = wr_fire && (wr_bank_i == active_q) && (wr_addr_i == rd_addr_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_bank_q  <= '0;
      rd_init_q  <= 1'b0;
      byp_ben_q  <= '0;
      byp_data_q <= '0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_bank_q  <= active_q;
        rd_init_q  <= init_active;
        byp_ben_q  <= byp_hit ? ben_i : '0;
        byp_data_q <= wr_data_i;
      end
    end
  end

  logic [DATA_W-1:0] merged;

  always_comb begin
    merged = bank_rd[rd_bank_q];
    for (int k = 0; k < NB; k++) begin
      if (byp_ben_q[k]) merged[k*BYTE_W +: BYTE_W] = byp_data_q[k*BYTE_W +: BYTE_W];
    end
  end

  assign rd_data_o  = rd_init_q ? '0 : merged;
  assign rd_valid_o = rd_valid_q;

endmodule
